l2_port_arbiter: RTL and testbench
==================================

Name: l2_port_arbiter

Overview:
- Shares the single L1-side port of the combined L2 cache between the L1 instruction-cache miss path (requester 0) and the L1 data-cache miss path (requester 1).
- Grants the port for a whole block transfer, either a read fill or a write-back.
- Sequences the L2 request handshake and counts the block's words.
- Returns per-requester read data, write-advance and done strobes.
- Sits between the two L1 caches' memory-side interfaces and the L2 cache's L1-side ports, inside the internal memory controller.

Parameters:
BW_ADDR, 24, word-address width
BW_DATA, 32, data word width
BLOCK_WORDS, 16, words per cache block; power of two, >= 2
BW_CNT, $clog2(BLOCK_WORDS), word-counter width (derived; not to be overridden)

Ports:
clock_i  in  1  single system clock; all logic is on the rising edge
reset_i  in  1  synchronous, active-high reset
req0_i / req1_i  in  1 each  requester request; level, held until its done pulse
rw0_i / rw1_i  in  1 each  1 = write-back to L2, 0 = read fill
add0_i / add1_i  in  BW_ADDR each  block base word address; low BW_CNT bits are ignored (forced 0)
wdata0_i / wdata1_i  in  BW_DATA each  current write word
wnext0_o / wnext1_o  out  1 each  write word consumed; requester advances to the next word
rdata0_o / rdata1_o  out  BW_DATA each  read word
rvalid0_o / rvalid1_o  out  1 each  rdata valid
done0_o / done1_o  out  1 each  one-cycle transfer-complete pulse
l2_req_o  out  1  request to L2
l2_rw_o  out  1  copy of the granted requester's rw
l2_add_o  out  BW_ADDR  base address | word count
l2_data_o  out  BW_DATA  granted requester's wdata
l2_ready_i  in  1  L2 accepts the request
l2_valid_i  in  1  one read word valid, or one write word accepted
l2_data_i  in  BW_DATA  read word from L2
busy_o  out  1  state != IDLE
err_o  out  1  sticky protocol error

Behaviour:
- Reset (synchronous, any state, including mid-transfer):
  - State goes to IDLE and the word counter to 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - All outputs are 0, including err_o.
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - If any reqN_i is high, latch grant, rw and base address. State goes to REQ next cycle.
  - Round-robin: if both requests are high, grant = !last_grant. Otherwise grant the single requester.
- REQ:
  - l2_req_o = 1 and l2_add_o = base.
  - l2_req_o stays held until l2_ready_i is sampled high; then state goes to XFER and counter = 0.
  - Latency from reqN_i high in IDLE to l2_req_o high is 1 cycle.
- XFER:
  - l2_req_o = 0 and l2_add_o = base | count.
  - On each cycle with l2_valid_i high, count increments.
  - Read transfer: rdataG_o <= l2_data_i and rvalidG_o <= 1, registered with 1-cycle latency.
  - Write transfer: l2_data_o = wdataG_i (combinational) and wnextG_o = l2_valid_i (combinational).
  - When l2_valid_i is high with count == BLOCK_WORDS-1: go to DONE and update last_grant = grant. The counter wraps to 0.
- DONE:
  - doneG_o = 1 for one cycle, then IDLE.
  - For a read, the last rvalid coincides with the done cycle.
  - The requester drops reqN_i on the edge after done. The request value in the following IDLE cycle is treated as a new request.
- Outputs of the non-granted requester are always 0.
- l2_rw_o and l2_data_o are 0 outside REQ/XFER.
- A change on reqN_i, addN_i or rwN_i after grant is ignored until DONE.
- err_o is set (sticky until reset) when:
  - l2_valid_i is high outside XFER, or
  - l2_ready_i is high outside REQ.
- There is no timeout; a stalled L2 holds the arbiter in REQ or XFER indefinitely.

Optional Feature:
- Macro: L2_PORT_ARBITER_PERF_EN.
- When defined, adds outputs perf_wait0_o and perf_wait1_o, 32 bits each.
  - perf_waitN_o counts cycles in which reqN_i is high while requester N is not the current grant, or state != IDLE before its grant.
  - The counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package l2_port_arbiter_pkg:
  - State enum (IDLE, REQ, XFER, DONE).
  - Requester index constants REQ_L1I = 0, REQ_L1D = 1.
  - Default BW_ADDR, BW_DATA, BLOCK_WORDS.
- One natural sub-module: rr_arbiter_2. It is combinational grant selection from req0/req1 and last_grant. The top instantiates it and registers its output.

Test Plan:
- Single read: req0 = 1, rw0 = 0, add0 = 0x000123, l2_ready after 3 cycles, 16 valids with data 0xA0..0xAF.
  - l2_add_o = 0x000120..0x00012F.
  - rdata0_o = 0xA0..0xAF, each one cycle after its valid.
  - done0 pulses with the last rvalid.
  - Requester 1 outputs stay 0.
- Simultaneous requests: req0 = req1 = 1 out of reset.
  - Requester 0 is served first, then requester 1.
  - With both held again, the grant alternates 0,1,0,1.
- Write-back: req1 = 1, rw1 = 1, l2_valid on alternating cycles.
  - wnext1 pulses exactly 16 times, each in the same cycle as l2_valid.
  - l2_data_o follows wdata1_i.
  - done1 is 1 cycle after the 16th valid.
- Reset mid-XFER after 7 words.
  - Next cycle: all outputs 0 and busy_o = 0.
  - A new req0 restarts at count 0.
- Spurious l2_valid_i in IDLE sets err_o = 1, which persists through later normal transfers until reset_i.
- PERF_EN build: req1 high during 20-cycle service of req0 gives perf_wait1_o = 20 at requester 1's grant.

Source files
------------

// File: rtl/l2_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter_pkg
// Shared definitions for the L2 L1-side port arbiter:
//   - state_t       : arbiter FSM states (IDLE, REQ, XFER, DONE)
//   - REQ_L1I/L1D   : requester indices (0 = I-cache miss path, 1 = D-cache)
//   - DEF_*         : default address/data widths and block size
// ---------------------------------------------------------------------------
package l2_port_arbiter_pkg;

    localparam int DEF_BW_ADDR     = 24;
    localparam int DEF_BW_DATA     = 32;
    localparam int DEF_BLOCK_WORDS = 16;

    localparam logic REQ_L1I = 1'b0;
    localparam logic REQ_L1D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/l2_port_arbiter_rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
// Combinational two-way round-robin pick. The caller registers the result.
//   req0_i, req1_i : requests from requester 0 / 1
//   last_grant_i   : requester served most recently
//   grant_o        : chosen requester index (valid only when valid_o = 1)
//   valid_o        : at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter_2
    import l2_port_arbiter_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic grant_o,
    output logic valid_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            // Tie: the requester that was not served last goes first.
            grant_o = ~last_grant_i;
        end else if (req1_i) begin
            grant_o = REQ_L1D;
        end else begin
            grant_o = REQ_L1I;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter
// Shares the L2 cache's single L1-side port between the L1 I-cache miss path
// (requester 0) and the L1 D-cache miss path (requester 1). A grant covers a
// whole block transfer (read fill or write-back): the arbiter issues the L2
// request, counts the block's words and returns per-requester strobes.
//
// Ports:
//   clock_i, reset_i          clock, synchronous active-high reset
//   reqN_i/rwN_i/addN_i       request level, direction (1 = write), base addr
//   wdataN_i / wnextN_o       write word in / word consumed strobe
//   rdataN_o / rvalidN_o      read word out (registered, 1 cycle after valid)
//   doneN_o                   one-cycle transfer-complete pulse
//   l2_req_o/l2_rw_o/l2_add_o request, direction and word address to L2
//   l2_data_o                 write word to L2
//   l2_ready_i/l2_valid_i     L2 accepts request / one word moved
//   l2_data_i                 read word from L2
//   busy_o                    transfer in progress
//   err_o                     sticky L2 handshake protocol error
// Optional build macro L2_PORT_ARBITER_PERF_EN adds perf_wait0_o/perf_wait1_o:
// saturating counts of cycles each requester spent waiting for the port.
// ---------------------------------------------------------------------------
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int BW_ADDR     = DEF_BW_ADDR,
    parameter int BW_DATA     = DEF_BW_DATA,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               req0_i,
    input  logic               req1_i,
    input  logic               rw0_i,
    input  logic               rw1_i,
    input  logic [BW_ADDR-1:0] add0_i,
    input  logic [BW_ADDR-1:0] add1_i,
    input  logic [BW_DATA-1:0] wdata0_i,
    input  logic [BW_DATA-1:0] wdata1_i,
    output logic               wnext0_o,
    output logic               wnext1_o,
    output logic [BW_DATA-1:0] rdata0_o,
    output logic [BW_DATA-1:0] rdata1_o,
    output logic               rvalid0_o,
    output logic               rvalid1_o,
    output logic               done0_o,
    output logic               done1_o,
    output logic               l2_req_o,
    output logic               l2_rw_o,
    output logic [BW_ADDR-1:0] l2_add_o,
    output logic [BW_DATA-1:0] l2_data_o,
    input  logic               l2_ready_i,
    input  logic               l2_valid_i,
    input  logic [BW_DATA-1:0] l2_data_i,
`ifdef L2_PORT_ARBITER_PERF_EN
    output logic [31:0]        perf_wait0_o,
    output logic [31:0]        perf_wait1_o,
`endif
    output logic               busy_o,
    output logic               err_o
);

    localparam int                 BW_CNT   = $clog2(BLOCK_WORDS);
    localparam logic [BW_CNT-1:0]  CNT_LAST = BW_CNT'(BLOCK_WORDS - 1);
    localparam logic [BW_ADDR-1:0] LOW_MASK = BW_ADDR'(BLOCK_WORDS - 1);

    state_t               state_q, state_d;
    logic                 grant_q, grant_d;
    logic                 rw_q, rw_d;
    logic [BW_ADDR-1:0]   base_q, base_d;
    logic [BW_CNT-1:0]    cnt_q, cnt_d;
    logic                 last_grant_q, last_grant_d;
    logic                 rvalid_q, rvalid_d;
    logic [BW_DATA-1:0]   rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic arb_grant;
    logic arb_valid;

    rr_arbiter_2 u_rr (
        .req0_i       (req0_i),
        .req1_i       (req1_i),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rw_d         = rw_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        rvalid_d     = 1'b0;
        rdata_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    rw_d    = arb_grant ? rw1_i : rw0_i;
                    base_d  = (arb_grant ? add1_i : add0_i) & ~LOW_MASK;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (l2_ready_i) begin
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (l2_valid_i) begin
                    // Counter wraps to 0 on the last word of the block.
                    cnt_d = cnt_q + 1'b1;
                    if (!rw_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = l2_data_i;
                    end
                    if (cnt_q == CNT_LAST) begin
                        last_grant_d = grant_q;
                        state_d      = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        err_d = err_q
              | (l2_valid_i && (state_q != ST_XFER))
              | (l2_ready_i && (state_q != ST_REQ));
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= REQ_L1I;
            rw_q         <= 1'b0;
            base_q       <= '0;
            cnt_q        <= '0;
            last_grant_q <= REQ_L1D;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rw_q         <= rw_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Output decode: everything is gated by the registered state and grant,
    // so the idle/reset state drives all outputs to zero.
    logic in_req, in_xfer, active, wnext;
    logic [BW_DATA-1:0] wdata_g;

    always_comb begin
        in_req  = (state_q == ST_REQ);
        in_xfer = (state_q == ST_XFER);
        active  = in_req | in_xfer;
        wnext   = in_xfer & rw_q & l2_valid_i;
        wdata_g = grant_q ? wdata1_i : wdata0_i;
    end

    assign l2_req_o  = in_req;
    assign l2_rw_o   = active & rw_q;
    assign l2_add_o  = in_req  ? base_q :
                       in_xfer ? (base_q | BW_ADDR'(cnt_q)) : '0;
    assign l2_data_o = (active && rw_q) ? wdata_g : '0;

    assign wnext0_o  = wnext & (grant_q == REQ_L1I);
    assign wnext1_o  = wnext & (grant_q == REQ_L1D);
    assign rvalid0_o = rvalid_q & (grant_q == REQ_L1I);
    assign rvalid1_o = rvalid_q & (grant_q == REQ_L1D);
    assign rdata0_o  = (grant_q == REQ_L1I) ? rdata_q : '0;
    assign rdata1_o  = (grant_q == REQ_L1D) ? rdata_q : '0;
    assign done0_o   = (state_q == ST_DONE) & (grant_q == REQ_L1I);
    assign done1_o   = (state_q == ST_DONE) & (grant_q == REQ_L1D);

    assign busy_o    = (state_q != ST_IDLE);
    assign err_o     = err_q;

`ifdef L2_PORT_ARBITER_PERF_EN
    // A requester is "served" while it owns the port, or in the IDLE cycle
    // where it wins arbitration; any other cycle with its request up is wait.
    logic [31:0] wait0_q, wait0_d, wait1_q, wait1_d;
    logic        served0, served1;

    always_comb begin
        if (state_q == ST_IDLE) begin
            served0 = arb_valid & (arb_grant == REQ_L1I);
            served1 = arb_valid & (arb_grant == REQ_L1D);
        end else begin
            served0 = (grant_q == REQ_L1I);
            served1 = (grant_q == REQ_L1D);
        end
        wait0_d = wait0_q;
        wait1_d = wait1_q;
        if (req0_i && !served0 && (wait0_q != 32'hFFFF_FFFF)) begin
            wait0_d = wait0_q + 32'd1;
        end
        if (req1_i && !served1 && (wait1_q != 32'hFFFF_FFFF)) begin
            wait1_d = wait1_q + 32'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wait0_q <= '0;
            wait1_q <= '0;
        end else begin
            wait0_q <= wait0_d;
            wait1_q <= wait1_d;
        end
    end

    assign perf_wait0_o = wait0_q;
    assign perf_wait1_o = wait1_q;
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_port_arbiter
// Self-checking bench for l2_port_arbiter. The bench plays both L1 requesters
// and the L2 cache. A table of block transactions (with the expected winner)
// is applied first, then hand sequences for reset mid-transfer and sticky
// error, then randomized transactions whose winner comes from a round-robin
// model. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_l2_port_arbiter;
    import l2_port_arbiter_pkg::*;

    localparam int          BLOCK = 16;
    localparam int          NONE  = 2;
    localparam logic [23:0] LOW   = 24'h00000F;

    logic        clk = 1'b0;
    logic        reset_i, req0_i, req1_i, rw0_i, rw1_i;
    logic [23:0] add0_i, add1_i;
    logic [31:0] wdata0_i, wdata1_i, l2_data_i;
    logic        wnext0_o, wnext1_o, rvalid0_o, rvalid1_o, done0_o, done1_o;
    logic [31:0] rdata0_o, rdata1_o, l2_data_o;
    logic        l2_req_o, l2_rw_o, l2_ready_i, l2_valid_i, busy_o, err_o;
    logic [23:0] l2_add_o;
    logic        any_out;

    int total = 0;
    int bad   = 0;
    int owner = NONE;     // requester the bench believes owns the port
    bit last_m = 1'b1;    // model: requester served most recently

    always #5 clk = ~clk;

`ifdef L2_PORT_ARBITER_PERF_EN
    logic [31:0] perf_wait0_o, perf_wait1_o;
    logic [31:0] exp_w0, exp_w1;
    always @(posedge clk) begin
        if (reset_i) begin
            exp_w0 <= '0;
            exp_w1 <= '0;
        end else begin
            if (req0_i && owner != 0 && exp_w0 != 32'hFFFF_FFFF) exp_w0 <= exp_w0 + 32'd1;
            if (req1_i && owner != 1 && exp_w1 != 32'hFFFF_FFFF) exp_w1 <= exp_w1 + 32'd1;
        end
    end
`endif

    l2_port_arbiter dut (
        .clock_i    (clk),
        .reset_i    (reset_i),
        .req0_i     (req0_i),
        .req1_i     (req1_i),
        .rw0_i      (rw0_i),
        .rw1_i      (rw1_i),
        .add0_i     (add0_i),
        .add1_i     (add1_i),
        .wdata0_i   (wdata0_i),
        .wdata1_i   (wdata1_i),
        .wnext0_o   (wnext0_o),
        .wnext1_o   (wnext1_o),
        .rdata0_o   (rdata0_o),
        .rdata1_o   (rdata1_o),
        .rvalid0_o  (rvalid0_o),
        .rvalid1_o  (rvalid1_o),
        .done0_o    (done0_o),
        .done1_o    (done1_o),
        .l2_req_o   (l2_req_o),
        .l2_rw_o    (l2_rw_o),
        .l2_add_o   (l2_add_o),
        .l2_data_o  (l2_data_o),
        .l2_ready_i (l2_ready_i),
        .l2_valid_i (l2_valid_i),
        .l2_data_i  (l2_data_i),
`ifdef L2_PORT_ARBITER_PERF_EN
        .perf_wait0_o (perf_wait0_o),
        .perf_wait1_o (perf_wait1_o),
`endif
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    assign any_out = |{wnext0_o, wnext1_o, rdata0_o, rdata1_o, rvalid0_o, rvalid1_o,
                       done0_o, done1_o, l2_req_o, l2_rw_o, l2_add_o, l2_data_o,
                       busy_o, err_o};

    typedef struct {
        bit          rst;     // reset before this transaction
        bit          r0, r1, rw0, rw1;
        logic [23:0] a0, a1;
        int          rdly;    // cycles in REQ before l2_ready
        int          gap;     // 0 = valid every cycle, 1 = alternate, 2 = random
        logic [31:0] dbase;   // read data base (0 = random words)
        bit          g;       // expected winner
    } vec_t;

    vec_t vt [8];

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_grp(input bit g, input bit ew, input bit ev,
                             input logic [31:0] ed, input bit edn);
        check1("wnext_granted", g ? wnext1_o : wnext0_o, ew);
        check1("rvalid_granted", g ? rvalid1_o : rvalid0_o, ev);
        if (ev) checkw("rdata_granted", 64'(g ? rdata1_o : rdata0_o), 64'(ed));
        check1("done_granted", g ? done1_o : done0_o, edn);
    endtask

    task automatic check_other(input bit g);
        logic noisy;
        noisy = g ? |{wnext0_o, rvalid0_o, done0_o, rdata0_o}
                  : |{wnext1_o, rvalid1_o, done1_o, rdata1_o};
        check1("other_quiet", noisy, 1'b0);
    endtask

    // Mid-transfer noise that the arbiter must ignore.
    task automatic jiggle(input bit g);
        if (g) begin
            req0_i = 1'($urandom);
            rw0_i  = 1'($urandom);
            add0_i = 24'($urandom);
            rw1_i  = 1'($urandom);
            add1_i = 24'($urandom);
        end else begin
            req1_i = 1'($urandom);
            rw1_i  = 1'($urandom);
            add1_i = 24'($urandom);
            rw0_i  = 1'($urandom);
            add0_i = 24'($urandom);
        end
    endtask

    task automatic do_reset();
        reset_i    = 1'b1;
        req0_i     = 1'b0;
        req1_i     = 1'b0;
        l2_valid_i = 1'b0;
        l2_ready_i = 1'b0;
        @(posedge clk); #1;
        reset_i = 1'b0;
        last_m  = 1'b1;
        owner   = NONE;
    endtask

    // One block transfer, starting in the IDLE cycle where the requests are
    // presented. stop_at < BLOCK abandons the transfer after that many words.
    task automatic serve(input bit g, input int rdly, input int gap, input int stop_at,
                         input bit perturb, input logic [31:0] dbase);
        logic        rw;
        logic [23:0] base;
        logic [31:0] dw, pd;
        bit          v, pv, alt;
        int          k;
        rw    = g ? rw1_i : rw0_i;
        base  = (g ? add1_i : add0_i) & ~LOW;
        owner = int'(g);
        @(negedge clk);
        check1("idle_busy", busy_o, 1'b0);
`ifdef L2_PORT_ARBITER_PERF_EN
        checkw("perf_wait0", 64'(perf_wait0_o), 64'(exp_w0));
        checkw("perf_wait1", 64'(perf_wait1_o), 64'(exp_w1));
`endif
        @(posedge clk); #1;
        for (int c = 0; c <= rdly; c++) begin
            l2_ready_i = (c == rdly);
            if (perturb) jiggle(g);
            @(negedge clk);
            check1("req_l2_req", l2_req_o, 1'b1);
            checkw("req_l2_add", 64'(l2_add_o), 64'(base));
            check1("req_l2_rw", l2_rw_o, rw);
            check_grp(g, 1'b0, 1'b0, 32'h0, 1'b0);
            check_other(g);
            @(posedge clk); #1;
        end
        l2_ready_i = 1'b0;
        k   = 0;
        pv  = 1'b0;
        pd  = '0;
        alt = 1'b1;
        while (k < stop_at) begin
            if (gap == 0) begin
                v = 1'b1;
            end else if (gap == 1) begin
                v   = alt;
                alt = !alt;
            end else begin
                v = 1'($urandom);
            end
            dw         = (dbase != 0) ? dbase + 32'(k) : $urandom;
            l2_valid_i = v;
            l2_data_i  = dw;
            wdata0_i   = $urandom;
            wdata1_i   = $urandom;
            if (perturb) jiggle(g);
            @(negedge clk);
            check1("xfer_l2_req", l2_req_o, 1'b0);
            checkw("xfer_l2_add", 64'(l2_add_o), 64'(base | 24'(k)));
            check_grp(g, rw & v, pv, pd, 1'b0);
            if (rw) checkw("xfer_l2_data", 64'(l2_data_o), 64'(g ? wdata1_i : wdata0_i));
            check_other(g);
            @(posedge clk); #1;
            pv = v & ~rw;
            pd = dw;
            if (v) k++;
        end
        l2_valid_i = 1'b0;
        if (stop_at >= BLOCK) begin
            @(negedge clk);
            check_grp(g, 1'b0, pv, pd, 1'b1);
            check1("done_busy", busy_o, 1'b1);
            check_other(g);
            @(posedge clk); #1;
            owner  = NONE;
            last_m = g;
        end
    endtask

    initial begin
        int m, gaps;
        bit g;

        //           rst   r0    r1    rw0   rw1   a0           a1          rdly gap dbase        g
        vt[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000123, 24'h000456, 3, 0, 32'h0000_00A0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h001000, 24'h002000, 1, 0, 32'h0000_0100, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h001000, 24'h002000, 0, 0, 32'h0000_0200, 1'b1};
        vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h001010, 24'h002010, 0, 2, 32'h0000_0300, 1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h001020, 24'h002020, 2, 1, 32'h0000_0400, 1'b1};
        vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000000, 24'h00FFF7, 0, 1, 32'h0000_0000, 1'b1};
        vt[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'hFFFFFF, 24'h000000, 2, 2, 32'h0000_0000, 1'b0};
        vt[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000030, 24'h000040, 0, 2, 32'h0000_0000, 1'b1};

        reset_i = 1'b1;
        {req0_i, req1_i, rw0_i, rw1_i, l2_ready_i, l2_valid_i} = '0;
        add0_i = '0; add1_i = '0;
        wdata0_i = '0; wdata1_i = '0; l2_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;

        @(negedge clk);
        check1("reset_outputs_zero", any_out, 1'b0);
        @(posedge clk); #1;

        // Table-driven block transactions.
        for (int i = 0; i < 8; i++) begin
            if (vt[i].rst) do_reset();
            req0_i = vt[i].r0;  req1_i = vt[i].r1;
            rw0_i  = vt[i].rw0; rw1_i  = vt[i].rw1;
            add0_i = vt[i].a0;  add1_i = vt[i].a1;
            serve(vt[i].g, vt[i].rdly, vt[i].gap, BLOCK, 1'b0, vt[i].dbase);
            $display("vector %0d: grant=%0d done", i, vt[i].g);
        end

        // Reset in the middle of a read after 7 words, then a clean restart.
        req0_i = 1'b1; req1_i = 1'b0; rw0_i = 1'b0; add0_i = 24'h000200;
        serve(1'b0, 0, 0, 7, 1'b0, 32'h0000_0300);
        do_reset();
        @(negedge clk);
        check1("reset_mid_xfer_quiet", any_out, 1'b0);
        check1("reset_mid_xfer_busy", busy_o, 1'b0);
        @(posedge clk); #1;
        req0_i = 1'b1; add0_i = 24'h000200;
        serve(1'b0, 1, 0, BLOCK, 1'b0, 32'h0000_0500);
        $display("sequence reset_mid_xfer done");

        // Spurious L2 handshakes set a sticky error.
        req0_i = 1'b0;
        l2_valid_i = 1'b1;
        @(posedge clk); #1;
        l2_valid_i = 1'b0;
        @(negedge clk);
        check1("err_spurious_valid", err_o, 1'b1);
        @(posedge clk); #1;
        req1_i = 1'b1; rw1_i = 1'b0; add1_i = 24'h000700;
        serve(1'b1, 0, 0, BLOCK, 1'b0, 32'h0000_0600);
        req1_i = 1'b0;
        @(negedge clk);
        check1("err_sticky", err_o, 1'b1);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        check1("err_cleared", err_o, 1'b0);
        @(posedge clk); #1;
        l2_ready_i = 1'b1;
        @(posedge clk); #1;
        l2_ready_i = 1'b0;
        @(negedge clk);
        check1("err_spurious_ready", err_o, 1'b1);
        @(posedge clk); #1;
        do_reset();
        $display("sequence sticky_error done");

        // Randomized transactions with a round-robin model picking the winner.
        for (int t = 0; t < 40; t++) begin
            req0_i = 1'b0;
            req1_i = 1'b0;
            gaps   = $urandom_range(0, 2);
            repeat (gaps) begin
                @(negedge clk);
                check1("idle_quiet", l2_req_o | busy_o, 1'b0);
                @(posedge clk); #1;
            end
            m      = $urandom_range(1, 3);
            req0_i = m[0];
            req1_i = m[1];
            rw0_i  = 1'($urandom);
            rw1_i  = 1'($urandom);
            add0_i = 24'($urandom);
            add1_i = 24'($urandom);
            g = (req0_i && req1_i) ? !last_m : req1_i;
            serve(g, $urandom_range(0, 4), $urandom_range(0, 2), BLOCK, 1'b1, 32'h0);
            $display("random %0d: grant=%0d", t, g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
